// File: rtl/retirement_serializer.sv
// Buffers retirement groups and emits them one valid slot per handshake.
// Define MURE_SERIALIZER_STATS_EN for drop/emit statistics counters.
package mure_pkg;
  localparam int XLEN      = 64;
  localparam int INST_LEN  = 32;
  localparam int CAUSE_LEN = 6;
  localparam int PRIV_LEN  = 2;
endpackage

module retirement_serializer
  import mure_pkg::*;
#(
  parameter  int NRET  = 2,
  parameter  int DEPTH = 16,
  localparam int PW    = (NRET > 1) ? $clog2(NRET) : 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NRET-1:0]                valid_i,
  input  logic [NRET-1:0][XLEN-1:0]      pc_i,
  input  logic [NRET-1:0][INST_LEN-1:0]  inst_data_i,
  input  logic [NRET-1:0]                compressed_i,
  input  logic [NRET-1:0]                exception_i,
  input  logic                           interrupt_i,
  input  logic                           eret_i,
  input  logic [CAUSE_LEN-1:0]           cause_i,
  input  logic [XLEN-1:0]                tval_i,
  input  logic [PRIV_LEN-1:0]            priv_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [XLEN-1:0]                pc_o,
  output logic [INST_LEN-1:0]            inst_data_o,
  output logic                           compressed_o,
  output logic                           exception_o,
  output logic                           interrupt_o,
  output logic                           eret_o,
  output logic [CAUSE_LEN-1:0]           cause_o,
  output logic [XLEN-1:0]                tval_o,
  output logic [PRIV_LEN-1:0]            priv_o,
  output logic [PW-1:0]                  port_o,
  output logic                           last_o,
  output logic [CW-1:0]                  usage_o,
  output logic                           overflow_o
`ifdef MURE_SERIALIZER_STATS_EN
  ,
  output logic [15:0]                    drop_cnt_o,
  output logic [31:0]                    emit_cnt_o
`endif
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e state_q, state_d;

  logic [NRET-1:0]                vld_m  [DEPTH];
  logic [NRET-1:0][XLEN-1:0]      pc_m   [DEPTH];
  logic [NRET-1:0][INST_LEN-1:0]  inst_m [DEPTH];
  logic [NRET-1:0]                cmp_m  [DEPTH];
  logic [NRET-1:0]                exc_m  [DEPTH];
  logic                           irq_m  [DEPTH];
  logic                           eret_m [DEPTH];
  logic [CAUSE_LEN-1:0]           cause_m[DEPTH];
  logic [XLEN-1:0]                tval_m [DEPTH];
  logic [PRIV_LEN-1:0]            priv_m [DEPTH];

  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   slot_q, cur;
  logic            ovf_q;
  logic [NRET-1:0] hv;
  logic            any_v, full, hs, last, pop, push, drop;

  assign hv    = vld_m[rptr_q];
  assign any_v = |valid_i;
  assign full  = cnt_q == CW'(DEPTH);
  assign hs    = valid_o && ready_i;
  assign pop   = hs && last;
  assign push  = any_v && (!full || pop);
  assign drop  = any_v && full && !pop;

  // slot_q is a lower bound; the emitted slot is the first valid one at or above it
  always_comb begin
    logic found;
    found = 1'b0;
    cur   = slot_q;
    last  = 1'b1;
    for (int i = 0; i < NRET; i++) begin
      if (!found && PW'(i) >= slot_q && hv[i]) begin
        cur   = PW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NRET; i++) begin
      if (hv[i] && PW'(i) > cur) last = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (push) state_d = EMIT;
      EMIT: if (pop && !push && cnt_q == CW'(1)) state_d = IDLE;
    endcase
  end

  assign valid_o = state_q == EMIT;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      slot_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      if (pop)     slot_q <= '0;
      else if (hs) slot_q <= cur + 1'b1;
      if (drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      vld_m[wptr_q]   <= valid_i;
      pc_m[wptr_q]    <= pc_i;
      inst_m[wptr_q]  <= inst_data_i;
      cmp_m[wptr_q]   <= compressed_i;
      exc_m[wptr_q]   <= exception_i;
      irq_m[wptr_q]   <= interrupt_i;
      eret_m[wptr_q]  <= eret_i;
      cause_m[wptr_q] <= cause_i;
      tval_m[wptr_q]  <= tval_i;
      priv_m[wptr_q]  <= priv_i;
    end
  end

  always_comb begin
    pc_o         = '0;
    inst_data_o  = '0;
    compressed_o = 1'b0;
    exception_o  = 1'b0;
    interrupt_o  = 1'b0;
    eret_o       = 1'b0;
    cause_o      = '0;
    tval_o       = '0;
    priv_o       = '0;
    port_o       = '0;
    last_o       = 1'b0;
    if (valid_o) begin
      pc_o         = pc_m[rptr_q][cur];
      inst_data_o  = inst_m[rptr_q][cur];
      compressed_o = cmp_m[rptr_q][cur];
      exception_o  = exc_m[rptr_q][cur];
      interrupt_o  = irq_m[rptr_q];
      eret_o       = eret_m[rptr_q];
      cause_o      = cause_m[rptr_q];
      tval_o       = tval_m[rptr_q];
      priv_o       = priv_m[rptr_q];
      port_o       = cur;
      last_o       = last;
    end
  end

  assign usage_o    = cnt_q;
  assign overflow_o = ovf_q;

`ifdef MURE_SERIALIZER_STATS_EN
  logic [15:0] drop_q;
  logic [31:0] emit_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_q <= '0;
      emit_q <= '0;
    end else begin
      if (drop && drop_q != '1) drop_q <= drop_q + 1'b1;
      if (hs) emit_q <= emit_q + 1'b1;
    end
  end

  assign drop_cnt_o = drop_q;
  assign emit_cnt_o = emit_q;
`endif

endmodule

// File: tb/tb_retirement_serializer.sv
// Directed and scoreboarded checks for retirement_serializer.
// Runs with NRET=4, DEPTH=4.
module tb_retirement_serializer;
  import mure_pkg::*;

  localparam int NRET  = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [INST_LEN-1:0] inst;
    logic [1:0]          port;
    logic                last;
  } slot_t;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic [NRET-1:0] valid_i = '0;
  logic [NRET-1:0][XLEN-1:0] pc_i = '0;
  logic [NRET-1:0][INST_LEN-1:0] inst_data_i = '0;
  logic [NRET-1:0] compressed_i = '0;
  logic [NRET-1:0] exception_i = '0;
  logic interrupt_i = 1'b0;
  logic eret_i = 1'b0;
  logic [CAUSE_LEN-1:0] cause_i = '0;
  logic [XLEN-1:0] tval_i = '0;
  logic [PRIV_LEN-1:0] priv_i = '0;
  logic ready_i = 1'b0;
  logic valid_o;
  logic [XLEN-1:0] pc_o;
  logic [INST_LEN-1:0] inst_data_o;
  logic compressed_o, exception_o, interrupt_o, eret_o;
  logic [CAUSE_LEN-1:0] cause_o;
  logic [XLEN-1:0] tval_o;
  logic [PRIV_LEN-1:0] priv_o;
  logic [1:0] port_o;
  logic last_o;
  logic [2:0] usage_o;
  logic overflow_o;
`ifdef MURE_SERIALIZER_STATS_EN
  logic [15:0] drop_cnt_o;
  logic [31:0] emit_cnt_o;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  retirement_serializer #(.NRET(NRET), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i),
    .inst_data_i(inst_data_i), .compressed_i(compressed_i),
    .exception_i(exception_i), .interrupt_i(interrupt_i),
    .eret_i(eret_i), .cause_i(cause_i), .tval_i(tval_i),
    .priv_i(priv_i), .valid_o(valid_o), .ready_i(ready_i),
    .pc_o(pc_o), .inst_data_o(inst_data_o),
    .compressed_o(compressed_o), .exception_o(exception_o),
    .interrupt_o(interrupt_o), .eret_o(eret_o), .cause_o(cause_o),
    .tval_o(tval_o), .priv_o(priv_o), .port_o(port_o),
    .last_o(last_o), .usage_o(usage_o), .overflow_o(overflow_o)
`ifdef MURE_SERIALIZER_STATS_EN
    , .drop_cnt_o(drop_cnt_o), .emit_cnt_o(emit_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] want);
    nvec++;
    assert (obs === want) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  slot_t q[$];
  logic [127:0] e;
  int sent, gcnt, cyc, hi;
  logic [XLEN-1:0] drain_pc [4];

  initial begin
    // reset state
    step();
    rst_i = 1'b0;
    chk("rst_valid", valid_o, 0);
    chk("rst_usage", usage_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_pc", pc_o, 0);

    // two-slot group, ports 0 and 1
    ready_i = 1'b1;
    valid_i = 4'b0011;
    pc_i[0] = 64'h100;
    pc_i[1] = 64'h104;
    step();
    valid_i = '0;
    chk("g2_s0", {valid_o, pc_o, port_o, last_o}, {1'b1, 64'h100, 2'd0, 1'b0});
    chk("g2_use", usage_o, 1);
    step();
    chk("g2_s1", {valid_o, pc_o, port_o, last_o}, {1'b1, 64'h104, 2'd1, 1'b1});
    step();
    chk("g2_empty", {valid_o, usage_o, pc_o}, 0);

    // sparse group 1010 with group-wide fields
    valid_i = 4'b1010;
    pc_i = {64'h1330, 64'hbad, 64'h1110, 64'hbad};
    interrupt_i = 1'b1;
    cause_i = 6'd5;
    tval_i = 64'hdead;
    priv_i = 2'd3;
    step();
    valid_i = '0;
    interrupt_i = 1'b0;
    cause_i = '0;
    tval_i = '0;
    priv_i = '0;
    chk("sp_s0", {valid_o, pc_o, port_o, last_o}, {1'b1, 64'h1110, 2'd1, 1'b0});
    chk("sp_grp0", {interrupt_o, cause_o, tval_o, priv_o},
        {1'b1, 6'd5, 64'hdead, 2'd3});
    step();
    chk("sp_s1", {valid_o, pc_o, port_o, last_o}, {1'b1, 64'h1330, 2'd3, 1'b1});
    chk("sp_grp1", {interrupt_o, cause_o, tval_o, priv_o},
        {1'b1, 6'd5, 64'hdead, 2'd3});
    step();
    chk("sp_zero", {valid_o, interrupt_o, cause_o, tval_o, priv_o, last_o}, 0);

    // overflow: five groups into a four-deep FIFO with no drain
    ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      valid_i = 4'b0001;
      pc_i[0] = 64'h200 + 64'(16 * k);
      step();
      if (k == 3) chk("ov_full", {usage_o, overflow_o}, {3'd4, 1'b0});
    end
    valid_i = '0;
    chk("ov_drop", {usage_o, overflow_o}, {3'd4, 1'b1});
`ifdef MURE_SERIALIZER_STATS_EN
    chk("ov_dcnt", drop_cnt_o, 1);
`endif
    ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("ov_drain", {valid_o, pc_o, last_o}, {1'b1, 64'h200 + 64'(16 * k), 1'b1});
      step();
    end
    chk("ov_end", {valid_o, usage_o, overflow_o}, {1'b0, 3'd0, 1'b1});

    // reset while the head group is half emitted
    do_reset();
    chk("rs_clear_ovf", overflow_o, 0);
    ready_i = 1'b1;
    valid_i = 4'b0111;
    pc_i = {64'hbad, 64'h308, 64'h304, 64'h300};
    step();
    valid_i = '0;
    chk("rs_s0", pc_o, 64'h300);
    step();
    chk("rs_s1", pc_o, 64'h304);
    rst_i = 1'b1;
    valid_i = 4'b1111;
    step();
    rst_i = 1'b0;
    valid_i = '0;
    chk("rs_empty", {valid_o, usage_o}, 0);
    valid_i = 4'b1100;
    pc_i = {64'h40c, 64'h408, 64'hbad, 64'hbad};
    step();
    valid_i = '0;
    chk("rs_next0", {valid_o, pc_o, port_o, last_o}, {1'b1, 64'h408, 2'd2, 1'b0});
    step();
    chk("rs_next1", {valid_o, pc_o, port_o, last_o}, {1'b1, 64'h40c, 2'd3, 1'b1});
    step();
    chk("rs_done", valid_o, 0);

    // full FIFO with push and final-slot pop in the same cycle
    ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      valid_i = 4'b0001;
      pc_i[0] = 64'h500 + 64'(k);
      step();
    end
    chk("fp_full", usage_o, 4);
    valid_i = 4'b0001;
    pc_i[0] = 64'h5f0;
    ready_i = 1'b1;
    step();
    valid_i = '0;
    chk("fp_keep", {usage_o, overflow_o, pc_o}, {3'd4, 1'b0, 64'h501});
`ifdef MURE_SERIALIZER_STATS_EN
    chk("fp_dcnt", drop_cnt_o, 0);
`endif
    drain_pc = '{64'h501, 64'h502, 64'h503, 64'h5f0};
    for (int k = 0; k < 4; k++) begin
      chk("fp_drain", {valid_o, pc_o}, {1'b1, drain_pc[k]});
      step();
    end
    chk("fp_end", {valid_o, usage_o}, 0);

    // 100 random groups, ready toggling, against a slot scoreboard
    do_reset();
    sent = 0;
    gcnt = 0;
    cyc = 0;
    while ((sent < 100 || q.size() != 0) && cyc < 3000) begin
      e = '0;
      if (q.size() != 0) e = {1'b1, q[0]};
      chk("rnd_slot", {valid_o, pc_o, inst_data_o, port_o, last_o}, e);
      ready_i = (cyc % 2) == 0;
      valid_i = '0;
      if (sent < 100 && gcnt < DEPTH && $urandom_range(0, 1) == 1) begin
        valid_i = 4'($urandom_range(1, 15));
        for (int k = 0; k < NRET; k++) begin
          pc_i[k] = {$urandom, $urandom};
          inst_data_i[k] = $urandom;
        end
      end
      if (q.size() != 0 && ready_i) begin
        if (q[0].last) gcnt--;
        void'(q.pop_front());
      end
      if (valid_i != 0) begin
        hi = 0;
        for (int k = 0; k < NRET; k++) if (valid_i[k]) hi = k;
        for (int k = 0; k < NRET; k++) begin
          if (valid_i[k]) q.push_back('{pc_i[k], inst_data_i[k], 2'(k), k == hi});
        end
        gcnt++;
        sent++;
      end
      step();
      cyc++;
    end
    valid_i = '0;
    chk("rnd_done", {32'(sent), 32'(q.size())}, {32'd100, 32'd0});
    chk("rnd_end", {valid_o, usage_o, overflow_o}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/retirement_serializer.md
RETIREMENT_SERIALIZER -- requirements
Module: retirement_serializer

Interface
REQ-001 SHALL have parameter NRET, default 2, meaning number of commit ports, legal range 1..8.
REQ-002 SHALL have parameter DEPTH, default 16, meaning buffered commit groups, power of two, 2..64.
REQ-003 SHALL have ports: clk_i  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have ports: rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: valid_i  in  NRET  per-port retirement valid.
REQ-006 SHALL have ports: pc_i  in  NRET x mure_pkg::XLEN  per-port PC; inst_data_i  in  NRET x mure_pkg::INST_LEN; compressed_i  in  NRET; exception_i  in  NRET.
REQ-007 SHALL have ports: interrupt_i, eret_i  in  1 each; cause_i  in  mure_pkg::CAUSE_LEN; tval_i  in  mure_pkg::XLEN; priv_i  in  mure_pkg::PRIV_LEN; all group-wide.
REQ-008 SHALL have ports: valid_o  out  1; ready_i  in  1; pc_o, inst_data_o, compressed_o, exception_o, interrupt_o, eret_o, cause_o, tval_o, priv_o  out  widths as inputs; port_o  out  $clog2(NRET) (min 1) source port; last_o  out  1 last valid slot of group.
REQ-009 SHALL have ports: usage_o  out  $clog2(DEPTH)+1 groups stored; overflow_o  out  1 sticky drop flag.

Function
REQ-010 SHALL push one group (all NRET slots plus group-wide fields) when |valid_i and (not full or a group pop occurs same cycle); groups with valid_i==0 SHALL never be stored.
REQ-011 SHALL, when |valid_i while full and no pop that cycle, drop the group and set overflow_o next cycle; overflow_o SHALL hold until reset.
REQ-012 SHALL present head-group slots in ascending port index, skipping slots whose stored valid bit is 0.
REQ-013 SHALL drive valid_o=1 exactly when FIFO non-empty; output fields combinational from head group and slot pointer.
REQ-014 SHALL advance on valid_o&&ready_i: non-last slot -> pointer to next valid slot; last slot -> pop group, pointer to first valid slot of next group.
REQ-015 SHALL hold all output fields stable while valid_o&&!ready_i.
REQ-016 SHALL use FSM IDLE (empty), EMIT (head available): IDLE->EMIT on push; EMIT->IDLE on pop of last group with no same-cycle push; else stay.
REQ-017 SHALL have latency: group pushed in cycle N appears on valid_o in cycle N+1 (no bypass).
REQ-018 SHALL assert last_o on the highest-index valid slot of each group; single-valid group asserts last_o on its only slot.
REQ-019 SHALL wrap read/write pointers modulo DEPTH; usage_o = DEPTH when full, 0 when empty, unchanged on simultaneous push+pop.
REQ-020 SHALL copy group-wide fields (interrupt, eret, cause, tval, priv) onto every emitted slot of that group.
REQ-021 SHALL drive all data outputs to 0 when valid_o=0.

Reset
REQ-022 SHALL, with rst_i high at a clock edge, empty FIFO, clear slot pointer, state=IDLE, overflow_o=0, usage_o=0, valid_o=0, all outputs 0 from next cycle.
REQ-023 SHALL ignore valid_i and ready_i in any cycle rst_i is high; reset mid-group SHALL discard remaining slots.

Configuration
REQ-024 SHALL, with MURE_SERIALIZER_STATS_EN defined, add outputs drop_cnt_o (16 bit, saturating, counts dropped groups) and emit_cnt_o (32 bit, wrapping, counts valid_o&&ready_i handshakes), both reset to 0.
REQ-025 SHALL, without MURE_SERIALIZER_STATS_EN, omit both ports and counters; all other behaviour identical.

Verification
REQ-026 SHALL cover: NRET=2, push valid_i=2'b11 pc={0x104,0x100}, ready_i=1 -> cycle N+1 pc_o=0x100 port_o=0 last_o=0; N+2 pc_o=0x104 port_o=1 last_o=1; N+3 valid_o=0.
REQ-027 SHALL cover: NRET=4, valid_i=4'b1010 -> exactly two emits, port_o=1 then 3, last_o on port 3.
REQ-028 SHALL cover: DEPTH=4, ready_i=0, five consecutive groups -> usage_o=4, fifth dropped, overflow_o=1; drain -> 4 groups out in order, overflow_o stays 1.
REQ-029 SHALL cover: ready_i toggled 1/0 each cycle -> outputs stable on stalled cycles, no slot lost or duplicated over 100 random groups vs scoreboard.
REQ-030 SHALL cover: rst_i pulsed while head group half emitted -> next cycle valid_o=0, usage_o=0; following group emits from its first valid slot.
REQ-031 SHALL cover: full FIFO, push and final-slot handshake same cycle -> push accepted, usage_o stays DEPTH, overflow_o=0; with STATS_EN drop_cnt_o=0.
